// File: rtl/narrow_sat_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | narrow_sat_pkg: shared types and constants for the 32->16 narrower |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package narrow_sat_pkg;

  // Buffer occupancy: number of words currently held.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_state_t;

  localparam logic [15:0] SAT_S_MAX = 16'h7FFF;
  localparam logic [15:0] SAT_S_MIN = 16'h8000;
  localparam logic [15:0] SAT_U_MAX = 16'hFFFF;

  localparam int CNT_W_DEF = 8;

endpackage : narrow_sat_pkg
`default_nettype wire

// File: rtl/narrow_core.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | narrow_core: 16-bit range check and optional saturation (comb)     |
// | Saturation enabled by defining NARROW_SAT_EN, else values wrap.    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module narrow_core
  import narrow_sat_pkg::*;
(
  input  logic [31:0] in_data,
  input  logic        in_signed,
  output logic [15:0] out_data,
  output logic        out_ovf
);

  logic w_s_ok;
  logic w_u_ok;
  logic w_ovf;

  // Signed fits when bit 15 is replicated through bit 31.
  assign w_s_ok = (&in_data[31:15]) || !(|in_data[31:15]);
  assign w_u_ok = !(|in_data[31:16]);
  assign w_ovf  = in_signed ? !w_s_ok : !w_u_ok;

  always_comb begin
    out_ovf  = w_ovf;
    out_data = in_data[15:0];
`ifdef NARROW_SAT_EN
    if (w_ovf) begin
      if (in_signed) begin
        out_data = in_data[31] ? SAT_S_MIN : SAT_S_MAX;
      end else begin
        out_data = SAT_U_MAX;
      end
    end
`endif
  end

endmodule : narrow_core
`default_nettype wire

// File: rtl/narrow_sat.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | narrow_sat: 32->16 narrowing stage, 2-entry buffer, ovf counter    |
// | Out-of-range values saturate when NARROW_SAT_EN is defined.        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module narrow_sat
  import narrow_sat_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             out_ovf,
  output logic [CNT_W-1:0] ovf_cnt,
  input  logic             cnt_clr
);

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  occ_state_t       r_state;
  occ_state_t       w_state_nxt;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic [15:0]      w_core_data;
  logic             w_core_ovf;
  logic [15:0]      r_head_data;
  logic             r_head_ovf;
  logic [15:0]      r_skid_data;
  logic             r_skid_ovf;
  logic             w_load_head_in;
  logic             w_load_head_skid;
  logic             w_load_skid;
  logic [CNT_W-1:0] r_ovf_cnt;

  narrow_core u_core (
    .in_data   (in_data),
    .in_signed (in_signed),
    .out_data  (w_core_data),
    .out_ovf   (w_core_ovf)
  );

  assign w_in_xfer  = in_valid && w_in_ready;
  assign w_out_xfer = w_out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      EMPTY: if (w_in_xfer) w_state_nxt = ONE;
      ONE: begin
        if (w_in_xfer && !w_out_xfer) begin
          w_state_nxt = TWO;
        end else if (!w_in_xfer && w_out_xfer) begin
          w_state_nxt = EMPTY;
        end
      end
      TWO:     if (w_out_xfer) w_state_nxt = ONE;
      default: w_state_nxt = EMPTY;
    endcase
  end

  // Handshake outputs depend on the state register only.
  always_comb begin
    w_in_ready  = (r_state != TWO);
    w_out_valid = (r_state != EMPTY);
  end

  // Head is what the consumer sees; skid only fills when head is stalled.
  assign w_load_head_in   = w_in_xfer && ((r_state == EMPTY) || ((r_state == ONE) && w_out_xfer));
  assign w_load_head_skid = w_out_xfer && (r_state == TWO);
  assign w_load_skid      = w_in_xfer && (r_state == ONE) && !w_out_xfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head_data <= 16'h0000;
      r_head_ovf  <= 1'b0;
      r_skid_data <= 16'h0000;
      r_skid_ovf  <= 1'b0;
    end else begin
      if (w_load_head_in) begin
        r_head_data <= w_core_data;
        r_head_ovf  <= w_core_ovf;
      end else if (w_load_head_skid) begin
        r_head_data <= r_skid_data;
        r_head_ovf  <= r_skid_ovf;
      end
      if (w_load_skid) begin
        r_skid_data <= w_core_data;
        r_skid_ovf  <= w_core_ovf;
      end
    end
  end

  // Counted on acceptance so stalled words are already reflected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_cnt <= '0;
    end else if (cnt_clr) begin
      r_ovf_cnt <= '0;
    end else if (w_in_xfer && w_core_ovf && !(&r_ovf_cnt)) begin
      r_ovf_cnt <= r_ovf_cnt + c_cnt_one;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = r_head_data;
  assign out_ovf   = r_head_ovf;
  assign ovf_cnt   = r_ovf_cnt;

endmodule : narrow_sat
`default_nettype wire
